// File: rtl/filter_pkg.sv
// Shared constants and FSM state type for the 2-D filter front end.
package filter_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int PAD_SIZE   = 2;
    localparam int WIN        = 2*PAD_SIZE + 1;
    localparam int NUM_LINES  = WIN - 1;
    // Cycles from the first active i_mem_ren to the first window on o_win.
    localparam int PIPE_LAT   = 5;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
module line_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Write and registered read; same-address collision returns the old word
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/line_window_gen.sv
// Builds a WIN x WIN pixel window from four buffered lines plus the live line,
// with vertical pad-flag replication and horizontal edge replication.
module line_window_gen #(
    parameter int DATA_WIDTH     = filter_pkg::DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int PAD_SIZE       = filter_pkg::PAD_SIZE
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   i_vs,
    input  logic                                                   i_hs,
    input  logic                                                   i_mem_ren,
    input  logic [MEM_ADDR_WIDTH-1:0]                              i_mem_raddr,
    input  logic [MEM_ADDR_WIDTH-1:0]                              i_mem_waddr,
    input  logic [2*PAD_SIZE-1:0]                                  i_pad_y,
    input  logic [DATA_WIDTH-1:0]                                  i_data,
    output logic [filter_pkg::WIN*filter_pkg::WIN*DATA_WIDTH-1:0]  o_win,
    output logic                                                   o_valid,
    output logic                                                   o_vs,
    output logic                                                   o_hs
);
    import filter_pkg::*;

    localparam int WSEL_W = $clog2(NUM_LINES);
    localparam int CNT_W  = $clog2(PAD_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAD_SIZE - 1);

    logic                                   ren_d1, str_d1, armed;
    logic [DATA_WIDTH-1:0]                  data_d1;
    logic [2*PAD_SIZE-1:0]                  pad_d1;
    logic [WSEL_W-1:0]                      wsel;
    logic [NUM_LINES-1:0][DATA_WIDTH-1:0]   ram_q;
    logic [WIN-1:0][DATA_WIDTH-1:0]         raw, col_c, col_q, sr_in;
    logic                                   col_vld;
    logic [WIN-1:0][WIN-1:0][DATA_WIDTH-1:0] sr;   // sr[0] = leftmost column
    logic                                   sr_load, sr_shift;
    state_t                                 state;
    logic [CNT_W-1:0]                       cnt;
    logic [PIPE_LAT-1:0]                    vs_pipe, hs_pipe;

    // Input stage; 'armed' blocks a run already in progress after reset/vsync
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ren_d1  <= 1'b0;
            str_d1  <= 1'b0;
            armed   <= 1'b0;
            data_d1 <= '0;
            pad_d1  <= '0;
        end else begin
            ren_d1  <= i_mem_ren;
            str_d1  <= i_mem_ren & armed & ~i_vs;
            armed   <= i_vs ? 1'b0 : (armed | ~i_mem_ren);
            data_d1 <= i_data;
            pad_d1  <= i_pad_y;
        end
    end

    // Write pointer: advances once per line, frame sync rewinds it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        wsel <= '0;
        else if (i_vs)                  wsel <= '0;
        else if (ren_d1 && !i_mem_ren)  wsel <= wsel + 1'b1;
    end

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_ram
        line_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (MEM_ADDR_WIDTH)
        ) u_ram (
            .clk   (clk),
            .we    (ren_d1 && (wsel == WSEL_W'(g))),
            .waddr (i_mem_waddr),
            .wdata (data_d1),
            .re    (i_mem_ren),
            .raddr (i_mem_raddr),
            .rdata (ram_q[g])
        );
    end

    // Column assembly, oldest line first, then vertical pad replication
    always_comb begin
        raw = '0;
        for (int k = 0; k < NUM_LINES; k++) raw[k] = ram_q[wsel + WSEL_W'(k)];
        raw[WIN-1] = data_d1;
        col_c[0] = pad_d1[0] ? raw[2] : (pad_d1[1] ? raw[1] : raw[0]);
        col_c[1] = pad_d1[0] ? raw[2] : raw[1];
        col_c[2] = raw[2];
        col_c[3] = pad_d1[3] ? raw[2] : raw[3];
        col_c[4] = pad_d1[3] ? raw[2] : (pad_d1[2] ? raw[3] : raw[4]);
    end

    // Padded column register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            col_vld <= 1'b0;
        end else begin
            col_q   <= col_c;
            col_vld <= str_d1 & ~i_vs;
        end
    end

    // First column of a line fills the whole window (left replication);
    // FLUSH re-shifts the newest column (right replication).
    assign sr_load  = (state == IDLE) && col_vld;
    assign sr_shift = ((state == FILL || state == RUN) && col_vld) || (state == FLUSH);
    assign sr_in    = (state == FLUSH) ? sr[WIN-1] : col_q;

    // Column shift register, doubles as the registered window output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (sr_load) begin
            for (int k = 0; k < WIN; k++) sr[k] <= col_q;
        end else if (sr_shift) begin
            for (int k = 0; k < WIN-1; k++) sr[k] <= sr[k+1];
            sr[WIN-1] <= sr_in;
        end
    end

    // Line FSM; str_d1 is one cycle ahead of col_vld and flags the stream end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
        end else if (i_vs) begin
            state   <= IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_valid <= 1'b0;
                    cnt     <= '0;
                    if (col_vld) state <= FILL;
                end
                FILL: begin
                    if (!col_vld) begin
                        // Line shorter than PAD_SIZE+1: nothing to emit
                        state   <= IDLE;
                        o_valid <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= str_d1 ? RUN : FLUSH;
                        cnt     <= '0;
                        o_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    o_valid <= 1'b1;
                    if (!str_d1) begin
                        state <= FLUSH;
                        cnt   <= '0;
                    end
                end
                FLUSH: begin
                    o_valid <= 1'b1;
                    if (cnt == CNT_LAST) state <= IDLE;
                    else                 cnt   <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sync delay lines matching the window pipeline latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_pipe <= '0;
            hs_pipe <= '0;
        end else begin
            vs_pipe <= {vs_pipe[PIPE_LAT-2:0], i_vs};
            hs_pipe <= {hs_pipe[PIPE_LAT-2:0], i_hs};
        end
    end

    assign o_vs = vs_pipe[PIPE_LAT-1];
    assign o_hs = hs_pipe[PIPE_LAT-1];

    for (genvar r = 0; r < WIN; r++) begin : g_row
        for (genvar c = 0; c < WIN; c++) begin : g_col
            assign o_win[(r*WIN+c)*DATA_WIDTH +: DATA_WIDTH] = sr[c][r];
        end
    end

endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench for line_window_gen: pixel = {line[3:0], col[3:0]}.
module tb_line_window_gen;
    import filter_pkg::*;

    localparam int DW = 8;
    localparam int AW = 11;
    localparam int WW = WIN*WIN*DW;

    logic          clk = 1'b0;
    logic          rst, vs, hs, ren;
    logic [AW-1:0] raddr, waddr;
    logic [3:0]    pad;
    logic [DW-1:0] data;
    logic [WW-1:0] o_win;
    logic          o_valid, o_vs, o_hs;

    int n_cmp = 0;
    int n_err = 0;

    logic [WW-1:0] cap [0:31];
    logic [WW-1:0] win_hist [0:63];
    logic          v_hist [0:63];
    logic          vs_hist [0:63];
    logic          hs_hist [0:63];
    logic [1:0]    wsel_hist [0:63];
    int            ncap, first_vld;

    always #5 clk = ~clk;

    line_window_gen #(
        .DATA_WIDTH     (DW),
        .MEM_ADDR_WIDTH (AW),
        .PAD_SIZE       (PAD_SIZE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_vs        (vs),
        .i_hs        (hs),
        .i_mem_ren   (ren),
        .i_mem_raddr (raddr),
        .i_mem_waddr (waddr),
        .i_pad_y     (pad),
        .i_data      (data),
        .o_win       (o_win),
        .o_valid     (o_valid),
        .o_vs        (o_vs),
        .o_hs        (o_hs)
    );

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    function automatic logic [4:0][7:0] rows(input int a, input int b, input int c, input int d, input int e);
        logic [4:0][7:0] t;
        t[0] = 8'(a); t[1] = 8'(b); t[2] = 8'(c); t[3] = 8'(d); t[4] = 8'(e);
        return t;
    endfunction

    // Reference window: row r comes from line rl[r], columns clamp at 0 and w-1
    function automatic logic [WW-1:0] exp_win(input int k, input int w, input logic [4:0][7:0] rl);
        logic [WW-1:0] v;
        v = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                int col;
                col = k - PAD_SIZE + c;
                if (col < 0) col = 0;
                if (col > w-1) col = w-1;
                v[(r*WIN+c)*DW +: DW] = {rl[r][3:0], 4'(col)};
            end
        end
        return v;
    endfunction

    // One line of w pixels plus idle tail; optional vsync / reset pulse at a cycle
    task automatic drive_line(input int ln, input int w, input logic [3:0] pd,
                              input int vs_at, input int rst_at);
        ncap = 0;
        first_vld = -1;
        for (int n = 0; n < w + 12; n++) begin
            @(posedge clk);
            #1;
            ren   = (n < w);
            raddr = AW'(n);
            waddr = AW'(n - 1);
            data  = 8'((ln << 4) | n);
            pad   = (n < w) ? pd : 4'b0;
            hs    = (n == 0);
            vs    = (n == vs_at);
            rst   = (n == rst_at);
            @(negedge clk);
            v_hist[n]    = o_valid;
            vs_hist[n]   = o_vs;
            hs_hist[n]   = o_hs;
            win_hist[n]  = o_win;
            wsel_hist[n] = dut.wsel;
            if (o_valid) begin
                if (first_vld < 0) first_vld = n;
                if (ncap < 32) cap[ncap] = o_win;
                ncap++;
            end
        end
    endtask

    task automatic chk_line(input string nm, input int w, input logic [4:0][7:0] rl);
        chk({nm, "_nvld"}, ncap, w);
        chk({nm, "_first"}, first_vld, 5);
        for (int k = 0; k < w && k < 32; k++)
            chk($sformatf("%s_c%0d", nm, k), cap[k], exp_win(k, w, rl));
    endtask

    initial begin
        rst = 1'b1; vs = 1'b0; hs = 1'b0; ren = 1'b0;
        raddr = '0; waddr = '0; pad = '0; data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_win", o_win, 0);
        chk("rst_vs", o_vs, 0);
        chk("rst_hs", o_hs, 0);
        chk("rst_wsel", dut.wsel, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        drive_line(0, 8, 4'b0000, -1, -1);
        chk("l0_nvld", ncap, 8);
        chk("l0_first", first_vld, 5);
        chk("l0_hs4", hs_hist[4], 0);
        chk("l0_hs5", hs_hist[5], 1);
        drive_line(1, 8, 4'b0000, -1, -1);
        chk("l1_nvld", ncap, 8);

        drive_line(2, 8, 4'b0001, -1, -1);
        chk_line("l2_padtop", 8, rows(0, 0, 0, 1, 2));
        drive_line(3, 8, 4'b0010, -1, -1);
        chk_line("l3_pad1", 8, rows(0, 0, 1, 2, 3));
        drive_line(4, 8, 4'b0000, -1, -1);
        chk_line("l4", 8, rows(0, 1, 2, 3, 4));
        drive_line(5, 8, 4'b0000, -1, -1);
        chk_line("l5", 8, rows(1, 2, 3, 4, 5));
        drive_line(6, 8, 4'b1000, -1, -1);
        chk_line("l6_padbot", 8, rows(2, 3, 4, 4, 4));
        drive_line(7, 8, 4'b0100, -1, -1);
        chk_line("l7_pad2", 8, rows(3, 4, 5, 6, 6));
        drive_line(8, 3, 4'b0000, -1, -1);
        chk_line("l8_w3", 3, rows(4, 5, 6, 7, 8));

        drive_line(9, 2, 4'b0000, -1, -1);
        chk("w2_nvld", ncap, 0);
        chk("w2_state", dut.state, IDLE);

        drive_line(10, 8, 4'b0000, 7, -1);
        chk("vs_vld7", v_hist[7], 1);
        chk("vs_vld8", v_hist[8], 0);
        chk("vs_nvld", ncap, 3);
        chk("vs_wsel8", wsel_hist[8], 0);
        chk("vs_ovs11", vs_hist[11], 0);
        chk("vs_ovs12", vs_hist[12], 1);
        chk("vs_ovs13", vs_hist[13], 0);

        drive_line(11, 12, 4'b0000, -1, 7);
        chk("rstrun_vld6", v_hist[6], 1);
        chk("rstrun_vld7", v_hist[7], 0);
        chk("rstrun_win7", win_hist[7], 0);
        chk("rstrun_wsel7", wsel_hist[7], 0);
        chk("rstrun_nvld", ncap, 2);

        drive_line(12, 8, 4'b0000, -1, -1);
        chk("post_nvld", ncap, 8);
        chk("post_first", first_vld, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
